// File: rtl/proc_run_sequencer.sv
// Run-control sequencer: multi-program launch, branching, stall, saturating
// cycle/retired counters and sticky PC-overflow / illegal-program error.
module proc_run_sequencer #(
  parameter int PC_W        = 11,
  parameter int NUM_PROGS   = 4,
  parameter int PROG_STRIDE = 512,
  parameter int CYC_W       = 16,
  parameter int SEL_W       = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             BranchAbs,
  input  logic [PC_W-1:0]  Target,
  input  logic             Halt,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             PcValid,
  output logic             Busy,
  output logic             Ack,
  output logic             Err,
  output logic [CYC_W-1:0] CycleCt,
  output logic [CYC_W-1:0] InstrCt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [PC_W-1:0]  PC_MAX  = {PC_W{1'b1}};
  localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};

  state_t           state_r;
  state_t           nextState_s;
  logic [PC_W-1:0]  nextPc_s;
  logic             nextErr_s;
  logic [CYC_W-1:0] nextCyc_s;
  logic [CYC_W-1:0] nextIns_s;

  function automatic logic selIllegal(input logic [SEL_W-1:0] sel);
    logic [31:0] selWide;
    selWide = 32'(sel);
    if (selWide >= 32'(NUM_PROGS)) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

  // Entry address wraps into the PC range; illegal selections launch at 0.
  function automatic logic [PC_W-1:0] entryOf(input logic [SEL_W-1:0] sel);
    if (selIllegal(sel)) begin
      return {PC_W{1'b0}};
    end else begin
      return PC_W'(32'(sel) * 32'(PROG_STRIDE));
    end
  endfunction

  function automatic logic [CYC_W-1:0] satInc(input logic [CYC_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      return cnt;
    end else begin
      return cnt + CYC_W'(1);
    end
  endfunction

  // Next-state and next-register computation.
  always_comb begin
    nextState_s = state_r;
    nextPc_s    = ProgCtr;
    nextErr_s   = Err;
    nextCyc_s   = CycleCt;
    nextIns_s   = InstrCt;
    case (state_r)
      IDLE: begin
        if (Start) begin
          nextState_s = LOAD;
        end else begin
          nextState_s = IDLE;
        end
      end
      LOAD: begin
        nextPc_s  = entryOf(ProgSel);
        nextCyc_s = {CYC_W{1'b0}};
        nextIns_s = {CYC_W{1'b0}};
        if (Start) begin
          nextErr_s   = 1'b0;
          nextState_s = LOAD;
        end else begin
          nextErr_s   = selIllegal(ProgSel);
          nextState_s = RUN;
        end
      end
      RUN: begin
        nextCyc_s = satInc(CycleCt);
        if (Stall) begin
          nextPc_s = ProgCtr;
        end else begin
          nextIns_s = satInc(InstrCt);
          if (Halt) begin
            nextState_s = DONE;
          end else if (BranchEn) begin
            // Relative targets are two's complement; wrapping is legal.
            if (BranchAbs) begin
              nextPc_s = Target;
            end else begin
              nextPc_s = ProgCtr + Target;
            end
          end else if (ProgCtr == PC_MAX) begin
            nextErr_s   = 1'b1;
            nextState_s = DONE;
          end else begin
            nextPc_s = ProgCtr + PC_W'(1);
          end
        end
      end
      DONE: begin
        if (Start) begin
          nextState_s = LOAD;
        end else begin
          nextState_s = DONE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State, datapath registers and state-decoded flags registered together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      ProgCtr <= {PC_W{1'b0}};
      Err     <= 1'b0;
      CycleCt <= {CYC_W{1'b0}};
      InstrCt <= {CYC_W{1'b0}};
      PcValid <= 1'b0;
      Busy    <= 1'b0;
      Ack     <= 1'b0;
    end else begin
      state_r <= nextState_s;
      ProgCtr <= nextPc_s;
      Err     <= nextErr_s;
      CycleCt <= nextCyc_s;
      InstrCt <= nextIns_s;
      PcValid <= (nextState_s == RUN);
      Busy    <= (nextState_s == RUN) || (nextState_s == LOAD);
      Ack     <= (nextState_s == DONE);
    end
  end

endmodule

// File: tb/tb_proc_run_sequencer.sv
// Randomized bench for proc_run_sequencer against a behavioural model; a
// second instance with 4-bit counters exercises saturation.
module tb_proc_run_sequencer;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RUN  = 2;
  localparam int S_DONE = 3;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, BranchEn, BranchAbs, Halt;
  logic [1:0]  ProgSel;
  logic [10:0] Target;
  logic [10:0] ProgCtr, ProgCtr4;
  logic        PcValid, Busy, Ack, Err, PcValid4, Busy4, Ack4, Err4;
  logic [15:0] CycleCt, InstrCt;
  logic [3:0]  CycleCt4, InstrCt4;

  int checks = 0;
  int failures = 0;
  int mState, mPc, mErr, mCyc, mIns;

  always #5 Clk = ~Clk;

  proc_run_sequencer #(.PC_W(11), .NUM_PROGS(4), .PROG_STRIDE(512), .CYC_W(16), .SEL_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target), .Halt(Halt),
    .ProgCtr(ProgCtr), .PcValid(PcValid), .Busy(Busy), .Ack(Ack), .Err(Err),
    .CycleCt(CycleCt), .InstrCt(InstrCt));

  proc_run_sequencer #(.PC_W(11), .NUM_PROGS(4), .PROG_STRIDE(512), .CYC_W(4), .SEL_W(2)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target), .Halt(Halt),
    .ProgCtr(ProgCtr4), .PcValid(PcValid4), .Busy(Busy4), .Ack(Ack4), .Err(Err4),
    .CycleCt(CycleCt4), .InstrCt(InstrCt4));

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelReset();
    mState = S_IDLE; mPc = 0; mErr = 0; mCyc = 0; mIns = 0;
  endtask

  // Spec rules applied to the inputs sampled at the clock edge.
  task automatic modelStep();
    case (mState)
      S_IDLE: if (Start) mState = S_LOAD;
      S_LOAD: begin
        mPc = (int'(ProgSel) * 512) % 2048;
        mCyc = 0; mIns = 0;
        mErr = 0;
        if (!Start) mState = S_RUN;
      end
      S_RUN: begin
        mCyc++;
        if (!Stall) begin
          mIns++;
          if (Halt) mState = S_DONE;
          else if (BranchEn) mPc = BranchAbs ? int'(Target) : (mPc + int'(Target)) % 2048;
          else if (mPc == 2047) begin mErr = 1; mState = S_DONE; end
          else mPc = mPc + 1;
        end
      end
      default: if (Start) mState = S_LOAD;
    endcase
  endtask

  task automatic checkAll(input string tag);
    checkEq({tag, "_pc"}, 32'(ProgCtr), mPc);
    checkEq({tag, "_pcvalid"}, 32'(PcValid), (mState == S_RUN) ? 1 : 0);
    checkEq({tag, "_busy"}, 32'(Busy), (mState == S_RUN || mState == S_LOAD) ? 1 : 0);
    checkEq({tag, "_ack"}, 32'(Ack), (mState == S_DONE) ? 1 : 0);
    checkEq({tag, "_err"}, 32'(Err), mErr);
    checkEq({tag, "_cyc"}, 32'(CycleCt), sat(mCyc, 65535));
    checkEq({tag, "_ins"}, 32'(InstrCt), sat(mIns, 65535));
    checkEq({tag, "_cyc4"}, 32'(CycleCt4), sat(mCyc, 15));
    checkEq({tag, "_ins4"}, 32'(InstrCt4), sat(mIns, 15));
  endtask

  task automatic cycle(input logic st, input logic [1:0] sel, input logic stl, input logic br,
                       input logic ab, input logic [10:0] tg, input logic hl);
    Start = st; ProgSel = sel; Stall = stl; BranchEn = br; BranchAbs = ab; Target = tg; Halt = hl;
    @(posedge Clk);
    modelStep();
    #1;
    checkAll("cyc");
  endtask

  task automatic plain();
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic launch(input logic [1:0] sel);
    cycle(1'b1, sel, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    cycle(1'b0, sel, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic randomRun();
    int n;
    logic [1:0] sel;
    logic [10:0] tg;
    logic ab;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      sel = 2'($urandom_range(0, 3));
      cycle(1'b1, sel, 1'b0, 1'($urandom), 1'($urandom), 11'($urandom), 1'($urandom));
    end
    sel = 2'($urandom_range(0, 3));
    cycle(1'b0, sel, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    for (int k = 0; k < 40 && mState == S_RUN; k++) begin
      ab = 1'($urandom);
      if (ab) tg = 11'($urandom);
      else if ($urandom_range(0, 1) == 1) tg = 11'($urandom_range(0, 20));
      else tg = 11'(2048 - $urandom_range(1, 20));
      cycle(1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ab, tg, ($urandom_range(0, 9) == 0));
    end
    if (mState == S_RUN) cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) plain();
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; Stall = 1'b0; BranchEn = 1'b0;
    BranchAbs = 1'b0; Target = 11'd0; Halt = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    Reset = 1'b0;

    // Launch program 2 with Start held three cycles, run five, halt.
    repeat (3) cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    cycle(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    checkEq("tp1_entry", 32'(ProgCtr), 1024);
    repeat (5) plain();
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1);
    checkEq("tp1_pc", 32'(ProgCtr), 1029);
    checkEq("tp1_ack", 32'(Ack), 1);
    checkEq("tp1_cyc", 32'(CycleCt), 6);
    checkEq("tp1_ins", 32'(InstrCt), 6);

    // Relative/absolute branches, Halt beats BranchEn.
    launch(2'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 11'd20, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 11'h7FC, 1'b0);
    checkEq("rel_pc", 32'(ProgCtr), 16);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 11'd300, 1'b0);
    checkEq("abs_pc", 32'(ProgCtr), 300);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 11'd5, 1'b1);
    checkEq("haltbr_pc", 32'(ProgCtr), 300);
    checkEq("haltbr_ack", 32'(Ack), 1);

    // Stall masks Halt.
    launch(2'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 11'd7, 1'b0);
    repeat (3) cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 11'd0, 1'b1);
    checkEq("stall_pc", 32'(ProgCtr), 7);
    checkEq("stall_valid", 32'(PcValid), 1);
    checkEq("stall_cyc", 32'(CycleCt), 4);
    checkEq("stall_ins", 32'(InstrCt), 1);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1);
    checkEq("stall_ack", 32'(Ack), 1);
    checkEq("stall_ins2", 32'(InstrCt), 2);

    // Free-run program 3 into PC overflow.
    launch(2'd3);
    checkEq("ovf_entry", 32'(ProgCtr), 1536);
    repeat (512) plain();
    checkEq("ovf_err", 32'(Err), 1);
    checkEq("ovf_ack", 32'(Ack), 1);
    checkEq("ovf_pc", 32'(ProgCtr), 2047);
    checkEq("ovf_cyc4", 32'(CycleCt4), 15);
    checkEq("ovf_ins4", 32'(InstrCt4), 15);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    checkEq("relaunch_ack", 32'(Ack), 0);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    checkEq("relaunch_err", 32'(Err), 0);
    cycle(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1);

    // Asynchronous reset mid-RUN.
    launch(2'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 11'd40, 1'b0);
    #3;
    Reset = 1'b1;
    #1;
    modelReset();
    checkAll("areset");
    checkEq("areset_pc", 32'(ProgCtr), 0);
    #2;
    Reset = 1'b0;
    launch(2'd1);
    checkEq("postreset_pc", 32'(ProgCtr), 512);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1);

    repeat (60) randomRun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
